// File: rtl/dyn_console_scroll_if.sv
// Bus bundle for dyn_console_scroll.
//  master : the upstream side (sync generator / controller) that drives the
//           RGB stream, scroll requests and cursor position, and receives the
//           lookup results.
//  slave  : the console block itself.
// Signals:
//  RGBStr_i   26      stream: [0]Active [1]VS [2]HS [12:3]YC [22:13]XC [25:23]RGB
//  scroll_row RW      requested first displayed row
//  scroll_ld  1       strobe: capture scroll_row into the pending register
//  cur_col    8       cursor column
//  cur_row    8       cursor row (screen row, pre-scroll)
//  cur_en     1       cursor enable
//  RGBStr_o   26      stream delayed to stay aligned with the lookup outputs
//  addr_vram  ADDR_W  VRAM address of the character under the pixel
//  glyph_x/y  PS      pixel offset inside the glyph
//  in_text    1       pixel lies inside the text grid
//  cursor_hit 1       pixel lies in the visible cursor cell
interface dyn_console_scroll_if #(
  parameter int GLYPH  = 16,
  parameter int ROWS   = 30,
  parameter int ADDR_W = 11
);
  localparam int PS = $clog2(GLYPH);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic [25:0]       RGBStr_i;
  logic [RW-1:0]     scroll_row;
  logic              scroll_ld;
  logic [7:0]        cur_col;
  logic [7:0]        cur_row;
  logic              cur_en;

  logic [25:0]       RGBStr_o;
  logic [ADDR_W-1:0] addr_vram;
  logic [PS-1:0]     glyph_x;
  logic [PS-1:0]     glyph_y;
  logic              in_text;
  logic              cursor_hit;

  modport master (
    output RGBStr_i, scroll_row, scroll_ld, cur_col, cur_row, cur_en,
    input  RGBStr_o, addr_vram, glyph_x, glyph_y, in_text, cursor_hit
  );

  modport slave (
    input  RGBStr_i, scroll_row, scroll_ld, cur_col, cur_row, cur_en,
    output RGBStr_o, addr_vram, glyph_x, glyph_y, in_text, cursor_hit
  );
endinterface

// File: rtl/dyn_console_scroll.sv
// Dynamic text-console address generator.
// Taps the pixel stream from the VGA sync generator and, two cycles later,
// presents the VRAM address of the character cell under the pixel (with
// circular, frame-synchronous row scroll), the pixel offset inside the glyph,
// a grid-membership flag, a blinking cursor flag and the stream itself,
// delayed to stay aligned with those results.
// Ports:
//  px_clk  pixel clock
//  rst_n   synchronous reset, active low
//  bus     dyn_console_scroll_if.slave (stream, scroll and cursor controls,
//          lookup outputs)
module dyn_console_scroll #(
  parameter int GLYPH    = 16,
  parameter int COLS     = 40,
  parameter int ROWS     = 30,
  parameter int ADDR_W   = 11,
  parameter int BLINK_FR = 30
) (
  input  logic                 px_clk,
  input  logic                 rst_n,
  dyn_console_scroll_if.slave  bus
);
  localparam int DATA_W = 26;
  localparam int PS     = $clog2(GLYPH);
  localparam int RW     = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int VW     = 10 - PS;
  localparam int FW     = (BLINK_FR > 1) ? $clog2(BLINK_FR) : 1;

  // Circular row wrap; both operands are below ROWS whenever the result is
  // used, so one conditional subtract is enough.
  function automatic logic [RW-1:0] wrap_row(input logic [VW-1:0] vy,
                                             input logic [RW-1:0] ofs);
    logic [RW:0] s;
    s = (RW+1)'(vy) + {1'b0, ofs};
    if (s >= (RW+1)'(ROWS)) s = s - (RW+1)'(ROWS);
    return s[RW-1:0];
  endfunction

  function automatic logic [ADDR_W-1:0] cell_addr(input logic [RW-1:0] prow,
                                                  input logic [VW-1:0] vx);
    return ADDR_W'(prow) * ADDR_W'(COLS) + ADDR_W'(vx);
  endfunction

  logic [9:0] xc, yc;
  assign xc = bus.RGBStr_i[22:13];
  assign yc = bus.RGBStr_i[12:3];

  // stage 1 registers
  logic [DATA_W-1:0] rgb_p1_q, rgb_p1_d;
  logic [VW-1:0]     vx_p1_q, vx_p1_d, vy_p1_q, vy_p1_d;
  logic [PS-1:0]     gx_p1_q, gx_p1_d, gy_p1_q, gy_p1_d;
  logic              int_p1_q, int_p1_d;
  logic [RW-1:0]     prow_p1_q, prow_p1_d;
  // stage 2 registers (module outputs)
  logic [DATA_W-1:0] rgb_p2_q, rgb_p2_d;
  logic [ADDR_W-1:0] addr_p2_q, addr_p2_d;
  logic [PS-1:0]     gx_p2_q, gx_p2_d, gy_p2_q, gy_p2_d;
  logic              int_p2_q, int_p2_d;
  logic              hit_p2_q, hit_p2_d;
  // scroll / blink control
  logic [RW-1:0]     act_q, act_d, pend_q, pend_d;
  logic              pvld_q, pvld_d;
  logic              vs_q, vs_d;
  logic [FW-1:0]     fcnt_q, fcnt_d;
  logic              blink_q, blink_d;
  logic              frame_edge;

  always_comb begin
    // ---- stage 1: split coordinates, grid test, scrolled row
    rgb_p1_d  = bus.RGBStr_i;
    vx_p1_d   = xc[9:PS];
    vy_p1_d   = yc[9:PS];
    gx_p1_d   = xc[PS-1:0];
    gy_p1_d   = yc[PS-1:0];
    int_p1_d  = (32'(vx_p1_d) < 32'(COLS)) && (32'(vy_p1_d) < 32'(ROWS));
    prow_p1_d = wrap_row(vy_p1_d, act_q);

    // ---- stage 2: address and cursor (cursor inputs taken live here)
    rgb_p2_d  = rgb_p1_q;
    gx_p2_d   = gx_p1_q;
    gy_p2_d   = gy_p1_q;
    int_p2_d  = int_p1_q;
    addr_p2_d = int_p1_q ? cell_addr(prow_p1_q, vx_p1_q) : '0;
    hit_p2_d  = int_p1_q & bus.cur_en & blink_q &
                (32'(vx_p1_q) == 32'(bus.cur_col)) &
                (32'(vy_p1_q) == 32'(bus.cur_row));

    // ---- control: pending scroll applied only on VS rising edge
    frame_edge = bus.RGBStr_i[1] & ~vs_q;
    vs_d    = bus.RGBStr_i[1];
    act_d   = act_q;
    pend_d  = pend_q;
    pvld_d  = pvld_q;
    fcnt_d  = fcnt_q;
    blink_d = blink_q;
    if (frame_edge && pvld_q) begin
      act_d  = pend_q;
      pvld_d = 1'b0;
    end
    // A strobe on the frame edge lands in pend after the old pend was applied.
    if (bus.scroll_ld && (32'(bus.scroll_row) < 32'(ROWS))) begin
      pend_d = bus.scroll_row;
      pvld_d = 1'b1;
    end
    if (frame_edge) begin
      if (fcnt_q == FW'(BLINK_FR - 1)) begin
        fcnt_d  = '0;
        blink_d = ~blink_q;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
  end

  // Reset clears the pipeline as well so no stale pixel escapes afterwards.
  always_ff @(posedge px_clk) begin
    if (!rst_n) begin
      rgb_p1_q  <= '0;
      vx_p1_q   <= '0;
      vy_p1_q   <= '0;
      gx_p1_q   <= '0;
      gy_p1_q   <= '0;
      int_p1_q  <= 1'b0;
      prow_p1_q <= '0;
      rgb_p2_q  <= '0;
      addr_p2_q <= '0;
      gx_p2_q   <= '0;
      gy_p2_q   <= '0;
      int_p2_q  <= 1'b0;
      hit_p2_q  <= 1'b0;
      act_q     <= '0;
      pend_q    <= '0;
      pvld_q    <= 1'b0;
      vs_q      <= 1'b0;
      fcnt_q    <= '0;
      blink_q   <= 1'b1;
    end else begin
      rgb_p1_q  <= rgb_p1_d;
      vx_p1_q   <= vx_p1_d;
      vy_p1_q   <= vy_p1_d;
      gx_p1_q   <= gx_p1_d;
      gy_p1_q   <= gy_p1_d;
      int_p1_q  <= int_p1_d;
      prow_p1_q <= prow_p1_d;
      rgb_p2_q  <= rgb_p2_d;
      addr_p2_q <= addr_p2_d;
      gx_p2_q   <= gx_p2_d;
      gy_p2_q   <= gy_p2_d;
      int_p2_q  <= int_p2_d;
      hit_p2_q  <= hit_p2_d;
      act_q     <= act_d;
      pend_q    <= pend_d;
      pvld_q    <= pvld_d;
      vs_q      <= vs_d;
      fcnt_q    <= fcnt_d;
      blink_q   <= blink_d;
    end
  end

  assign bus.RGBStr_o   = rgb_p2_q;
  assign bus.addr_vram  = addr_p2_q;
  assign bus.glyph_x    = gx_p2_q;
  assign bus.glyph_y    = gy_p2_q;
  assign bus.in_text    = int_p2_q;
  assign bus.cursor_hit = hit_p2_q;
endmodule
